// File: rtl/whac_pkg.sv
// Shared types and constants for the whac-a-mole datapath: levels, window
// lengths, LFSR seed and the dispatcher state encoding.
package whac_pkg;

    typedef enum logic [1:0] {
        LVL_EASY   = 2'd0,
        LVL_MEDIUM = 2'd1,
        LVL_HARD   = 2'd2,
        LVL_HARD3  = 2'd3
    } level_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        EXPIRED  = 2'd2
    } dispatch_state_t;

    localparam int COUNT_W = 10;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Index 0 = easy, 1 = medium, 2 = hard.
    localparam logic [2:0][COUNT_W-1:0] WINDOW_TICKS = {10'd400, 10'd700, 10'd1000};

    // Level 3 shares the hard window.
    function automatic logic [COUNT_W-1:0] window_ticks(input level_t lvl);
        logic [COUNT_W-1:0] ticks;
        case (lvl)
            LVL_EASY:   ticks = WINDOW_TICKS[0];
            LVL_MEDIUM: ticks = WINDOW_TICKS[1];
            default:    ticks = WINDOW_TICKS[2];
        endcase
        return ticks;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16/14/13/11, reloaded with the
// seed on reset.
module lfsr16
    import whac_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Next-state shift with XOR feedback.
    always_comb begin
        state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/mole_dispatcher.sv
// Mole dispatcher: picks a pseudo-random mole, runs the level-dependent hit
// window and reports hit/expiry to the game FSM. Optional macro
// WRONG_SWITCH_MISS_EN makes a wrong-switch edge end the window as a miss.
module mole_dispatcher
    import whac_pkg::*;
#(
    parameter int N_MOLES     = 8,
    parameter int TICK_CYCLES = 50_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         level,
    input  logic               ready_for_mole,
    input  logic               timeout_start,
    input  logic               ledx,
    input  logic [N_MOLES-1:0] switches,
    output logic [N_MOLES-1:0] leds,
    output logic               switchx,
    output logic               timeout
);

    localparam int SEL_W = $clog2(N_MOLES);
    localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_CYCLES - 1);
    localparam logic [PRE_W-1:0]   PRE_ONE   = PRE_W'(1);
    localparam logic [SEL_W-1:0]   SEL_ONE   = SEL_W'(1);
    localparam logic [N_MOLES-1:0] LED_ONE   = N_MOLES'(1);
    localparam logic [15:0]        CAND_MASK = 16'((32'd1 << SEL_W) - 32'd1);

    dispatch_state_t    state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [SEL_W-1:0]   prev_mole_q, prev_mole_d;
    logic [N_MOLES-1:0] sync1_q, sync2_q, sw_prev_q;
    logic [N_MOLES-1:0] leds_q, leds_d;
    logic               switchx_q, switchx_d;
    logic               timeout_q, timeout_d;

    logic [15:0]        lfsr_s;
    logic [SEL_W-1:0]   candidate_s;
    logic               same_s;
    logic [N_MOLES-1:0] rise_s;
    logic [N_MOLES-1:0] sel_onehot_s;
    logic               hit_s;
    logic               wrong_s;
    logic               tick_s;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr_s)
    );

    // Edge detect, mole candidate and tick decode.
    always_comb begin
        candidate_s  = lfsr_s[SEL_W-1:0];
        // Compare on the masked word so the match ignores the unused LFSR bits.
        same_s       = ((lfsr_s & CAND_MASK) == {{(16-SEL_W){1'b0}}, prev_mole_q});
        rise_s       = sync2_q & ~sw_prev_q;
        sel_onehot_s = LED_ONE << prev_mole_q;
        hit_s        = |(rise_s & sel_onehot_s);
        wrong_s      = |(rise_s & ~sel_onehot_s);
        tick_s       = timeout_start && (pre_q == PRE_LAST);
    end

    // Next-state, window countdown and registered-output decode.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pre_d       = pre_q;
        prev_mole_d = prev_mole_q;
        switchx_d   = 1'b0;
        if (ready_for_mole) begin
            state_d     = ARMED;
            count_d     = window_ticks(level_t'(level));
            pre_d       = {PRE_W{1'b0}};
            prev_mole_d = same_s ? (candidate_s + SEL_ONE) : candidate_s;
        end else begin
            case (state_q)
                ARMED: begin
                    if (!timeout_start) begin
                        state_d = IDLE;
                    end else begin
                        if (tick_s) begin
                            pre_d   = {PRE_W{1'b0}};
                            count_d = count_q - 10'd1;
                        end else begin
                            pre_d = pre_q + PRE_ONE;
                        end
                        // Expiry outranks a hit landing in the same cycle.
                        if (tick_s && (count_q == 10'd1)) begin
                            state_d = EXPIRED;
                        end else if (hit_s) begin
                            state_d   = IDLE;
                            switchx_d = 1'b1;
`ifdef WRONG_SWITCH_MISS_EN
                        end else if (wrong_s) begin
                            state_d = EXPIRED;
`endif
                        end else begin
                            state_d = ARMED;
                        end
                    end
                end
                EXPIRED: begin
                    if (!timeout_start) begin
                        state_d = IDLE;
                    end else begin
                        state_d = EXPIRED;
                    end
                end
                IDLE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        if ((state_d == ARMED) && ledx) begin
            leds_d = LED_ONE << prev_mole_d;
        end else begin
            leds_d = {N_MOLES{1'b0}};
        end
        timeout_d = (state_d != EXPIRED);
    end

    // Switch synchroniser and previous-value register for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= {N_MOLES{1'b0}};
            sync2_q   <= {N_MOLES{1'b0}};
            sw_prev_q <= {N_MOLES{1'b0}};
        end else begin
            sync1_q   <= switches;
            sync2_q   <= sync1_q;
            sw_prev_q <= sync2_q;
        end
    end

    // Control state, window counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= {COUNT_W{1'b0}};
            pre_q       <= {PRE_W{1'b0}};
            prev_mole_q <= {SEL_W{1'b0}};
            leds_q      <= {N_MOLES{1'b0}};
            switchx_q   <= 1'b0;
            timeout_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pre_q       <= pre_d;
            prev_mole_q <= prev_mole_d;
            leds_q      <= leds_d;
            switchx_q   <= switchx_d;
            timeout_q   <= timeout_d;
        end
    end

    assign leds    = leds_q;
    assign switchx = switchx_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mole_dispatcher.sv
// Directed, table-driven bench for mole_dispatcher with N_MOLES=8, TICK_CYCLES=4.
module tb_mole_dispatcher;

    logic       clk;
    logic       rst_n;
    logic [1:0] level;
    logic       ready_for_mole;
    logic       timeout_start;
    logic       ledx;
    logic [7:0] switches;
    logic [7:0] leds;
    logic       switchx;
    logic       timeout;

    int checks = 0;
    int fails  = 0;
    int mole   = 0;

    mole_dispatcher #(.N_MOLES(8), .TICK_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .level          (level),
        .ready_for_mole (ready_for_mole),
        .timeout_start  (timeout_start),
        .ledx           (ledx),
        .switches       (switches),
        .leds           (leds),
        .switchx        (switchx),
        .timeout        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] lvl;
        int         hit_at;      // cycle after arming the switch rises; 0 = none
        bit         exp_pulse;
        int         exp_expire;  // edges after arming until timeout low; 0 = none
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [7:0] v);
        int r = -1;
        for (int i = 0; i < 8; i++) begin
            if (v[i] === 1'b1) r = i;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [1:0] lvl);
        level          = lvl;
        ready_for_mole = 1'b1;
        timeout_start  = 1'b1;
        ledx           = 1'b1;
        step();
        ready_for_mole = 1'b0;
        check("arm_onehot", $countones(leds), 32'd1);
        check("arm_timeout", timeout, 1'b1);
        mole = idx_of(leds);
        if (mole < 0) mole = 0;
    endtask

    task automatic go_idle();
        timeout_start = 1'b0;
        switches      = 8'h00;
        repeat (4) step();
    endtask

    vec_t vecs[9];

    initial begin
        int mole_ref;
        int prev;
        int m;
        int last;
        logic [7:0] seen;

        vecs[0] = '{2'd0, 20,   1'b1, 0};     // hit on easy
        vecs[1] = '{2'd1, 50,   1'b1, 0};
        vecs[2] = '{2'd2, 3,    1'b1, 0};
        vecs[3] = '{2'd2, 0,    1'b0, 1600};  // hard expiry
        vecs[4] = '{2'd0, 0,    1'b0, 4000};
        vecs[5] = '{2'd1, 0,    1'b0, 2800};
        vecs[6] = '{2'd3, 0,    1'b0, 1600};
        vecs[7] = '{2'd2, 1598, 1'b0, 1600};  // hit lands on expiry cycle
        vecs[8] = '{2'd2, 1597, 1'b1, 0};     // hit one cycle before expiry

        rst_n = 1'b0; level = 2'd0; ready_for_mole = 1'b0;
        timeout_start = 1'b0; ledx = 1'b0; switches = 8'h00;
        repeat (3) step();
        check("rst_leds", leds, 8'h00);
        check("rst_switchx", switchx, 1'b0);
        check("rst_timeout", timeout, 1'b1);

        // Arm a fixed number of cycles after reset release to capture the seeded pick.
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        arm(2'd0);
        mole_ref = mole;
        repeat (5) step();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_leds", leds, 8'h00);
        check("rst_async_switchx", switchx, 1'b0);
        check("rst_async_timeout", timeout, 1'b1);
        timeout_start = 1'b0; ledx = 1'b0;
        repeat (2) step();
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        arm(2'd0);
        check("lfsr_reseed", mole, mole_ref);
        go_idle();

        for (int v = 0; v < 9; v++) begin
            arm(vecs[v].lvl);
            last = (vecs[v].exp_expire > 0) ? vecs[v].exp_expire + 2 : vecs[v].hit_at + 4;
            for (int e = 1; e <= last; e++) begin
                if (vecs[v].hit_at > 0 && e == vecs[v].hit_at) switches[mole] = 1'b1;
                step();
                check("vec_switchx", switchx, (vecs[v].exp_pulse && e == vecs[v].hit_at + 2));
                check("vec_timeout", timeout,
                      (vecs[v].exp_expire == 0) || (e < vecs[v].exp_expire));
                if (vecs[v].exp_pulse && e == vecs[v].hit_at + 3)
                    check("vec_leds_after_hit", leds, 8'h00);
            end
            if (vecs[v].exp_expire > 0) begin
                timeout_start = 1'b0;
                step();
                check("expired_release", timeout, 1'b1);
            end
            go_idle();
        end

        // No immediate repeat over many arm/abort rounds; every mole appears.
        prev = mole;
        seen = 8'h00;
        for (int i = 0; i < 200; i++) begin
            arm(2'd0);
            m = mole;
            check("no_repeat", (m == prev), 1'b0);
            seen = seen | leds;
            prev = m;
            timeout_start = 1'b0;
            step();
            repeat (i % 3) step();
        end
        check("all_moles_seen", seen, 8'hFF);
        go_idle();

        // Switches held high across rearm never trigger.
        switches = 8'hFF;
        repeat (4) step();
        arm(2'd1);
        for (int k = 0; k < 10; k++) begin
            step();
            check("held_switchx", switchx, 1'b0);
        end
        go_idle();

        // Rearm in the same cycle as the hit edge: no pulse.
        arm(2'd1);
        prev = mole;
        switches[mole] = 1'b1;
        step();
        step();
        ready_for_mole = 1'b1;
        step();
        ready_for_mole = 1'b0;
        check("rearm_vs_hit", switchx, 1'b0);
        m = idx_of(leds);
        check("rearm_new_mole", (m == prev), 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("rearm_held_switchx", switchx, 1'b0);
        end
        go_idle();

        // Edge on a non-selected switch.
        arm(2'd2);
        switches[(mole + 1) % 8] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("wrong_sw_switchx", switchx, 1'b0);
        end
`ifdef WRONG_SWITCH_MISS_EN
        check("wrong_sw_timeout", timeout, 1'b0);
        check("wrong_sw_leds", leds, 8'h00);
`else
        check("wrong_sw_timeout", timeout, 1'b1);
        check("wrong_sw_leds", leds, 32'd1 << mole);
`endif
        go_idle();
        check("final_idle_timeout", timeout, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
